// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback
// sources, with a pending-write scoreboard for RAW hazard and WAW issue checks.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid,
   input  logic [AW-1:0]        iss_rd,
   output logic                 iss_ready,
   input  logic [AW-1:0]        rs1,
   input  logic [AW-1:0]        rs2,
   output logic                 rs1_hazard,
   output logic                 rs2_hazard,
   input  logic                 r0_valid,
   output logic                 r0_ready,
   input  logic [AW-1:0]        r0_rd,
   input  logic [XLEN-1:0]      r0_data,
   input  logic                 r1_valid,
   output logic                 r1_ready,
   input  logic [AW-1:0]        r1_rd,
   input  logic [XLEN-1:0]      r1_data,
   output logic                 wb_we,
   output logic [AW-1:0]        wb_rd,
   output logic [XLEN-1:0]      wb_data,
   output logic [(1<<AW)-1:0]   pending
);

   localparam int NREG = 1 << AW;

   logic                last_grant_q, last_grant_d;
   logic                wb_we_q, wb_we_d;
   logic [AW-1:0]       wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]     wb_data_q, wb_data_d;
   logic [NREG-1:0]     pending_q, pending_d;

   logic                gnt0, gnt1, hs;
   logic [AW-1:0]       hs_rd;
   logic [XLEN-1:0]     hs_data;
   logic [NREG-1:0]     set_vec, clr_vec;

   // Grants are suppressed while reset is held so nothing is accepted and lost.
   // last_grant_q: 0 = r0 granted last, 1 = r1 granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (r0_valid && r1_valid) begin
            if (last_grant_q) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
         end else if (r0_valid) begin
            gnt0 = 1'b1;
         end else if (r1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;
   assign hs       = gnt0 | gnt1;
   assign hs_rd    = gnt0 ? r0_rd   : r1_rd;
   assign hs_data  = gnt0 ? r0_data : r1_data;

   assign iss_ready = ~(pending_q[iss_rd] & (iss_rd != '0));

   assign rs1_hazard = (rs1 != '0) & (pending_q[rs1] | (wb_we_q & (wb_rd_q == rs1)));
   assign rs2_hazard = (rs2 != '0) & (pending_q[rs2] | (wb_we_q & (wb_rd_q == rs2)));

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_valid && iss_ready && (iss_rd != '0)) set_vec = NREG'(1) << iss_rd;
      if (hs) clr_vec = NREG'(1) << hs_rd;
   end

   // x0 writes are accepted but never reach the register file or the scoreboard.
   always_comb begin
      last_grant_d = last_grant_q;
      wb_we_d      = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      if (hs) begin
         last_grant_d = gnt1;
         if (hs_rd != '0) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = hs_rd;
            wb_data_d = hs_data;
         end
      end
      pending_d = ((pending_q & ~clr_vec) | set_vec) & ~NREG'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         wb_we_q      <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         pending_q    <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wb_we_q      <= wb_we_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         pending_q    <= pending_d;
      end
   end

   assign wb_we   = wb_we_q;
   assign wb_rd   = wb_rd_q;
   assign wb_data = wb_data_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, contention,
// scoreboard hazards, x0 handling and reset during an in-flight write.
module tb_regfile_wb_arbiter;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             iss_valid;
   logic [AW-1:0]    iss_rd;
   logic             iss_ready;
   logic [AW-1:0]    rs1, rs2;
   logic             rs1_hazard, rs2_hazard;
   logic             r0_valid, r0_ready;
   logic [AW-1:0]    r0_rd;
   logic [XLEN-1:0]  r0_data;
   logic             r1_valid, r1_ready;
   logic [AW-1:0]    r1_rd;
   logic [XLEN-1:0]  r1_data;
   logic             wb_we;
   logic [AW-1:0]    wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic [31:0]      pending;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .rs1(rs1), .rs2(rs2), .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rd(r0_rd), .r0_data(r0_data),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rd(r1_rd), .r1_data(r1_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
      r0_valid = 1'b1; r0_rd = 5'd2; r0_data = 32'h55;
      r1_valid = 1'b0; r1_rd = '0; r1_data = '0;
      tick();
      #1 chk("rst_r0_ready", r0_ready, 0);
      tick();
      chk("rst_wb_we", wb_we, 0);
      chk("rst_pending", pending, 0);
      #1 chk("rst_r0_ready2", r0_ready, 0);
      tick();
      rst = 1'b0;
      #1 chk("post_rst_r0_ready", r0_ready, 1);
      chk("post_rst_r1_ready", r1_ready, 0);
      tick();
      chk("post_rst_wb_we", wb_we, 1);
      chk("post_rst_wb_rd", wb_rd, 2);
      r0_valid = 1'b0;

      // single write
      r0_valid = 1'b1; r0_rd = 5'd5; r0_data = 32'hDEADBEEF;
      #1 chk("single_r0_ready", r0_ready, 1);
      tick();
      chk("single_wb_we", wb_we, 1);
      chk("single_wb_rd", wb_rd, 5);
      chk("single_wb_data", wb_data, 32'hDEADBEEF);
      r0_valid = 1'b0;
      tick();
      chk("single_wb_we_off", wb_we, 0);
      chk("single_wb_rd_hold", wb_rd, 5);
      chk("single_wb_data_hold", wb_data, 32'hDEADBEEF);

      // r1 alone so that r1 holds last grant before contention
      r1_valid = 1'b1; r1_rd = 5'd6; r1_data = 32'h66;
      #1 chk("r1_only_ready", r1_ready, 1);
      tick();
      chk("r1_only_wb_rd", wb_rd, 6);
      r1_valid = 1'b0;

      // contention: expect r0,r1,r0,r1
      r0_valid = 1'b1; r0_rd = 5'd3; r0_data = 32'hA3A3A3A3;
      r1_valid = 1'b1; r1_rd = 5'd4; r1_data = 32'hB4B4B4B4;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont%0d_r0_ready", i), r0_ready, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("cont%0d_r1_ready", i), r1_ready, (i % 2 == 0) ? 0 : 1);
         tick();
         chk($sformatf("cont%0d_wb_rd", i), wb_rd, (i % 2 == 0) ? 3 : 4);
         chk($sformatf("cont%0d_wb_data", i), wb_data,
             (i % 2 == 0) ? 32'hA3A3A3A3 : 32'hB4B4B4B4);
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
      tick();

      // scoreboard: issue rd=7 then read it
      iss_valid = 1'b1; iss_rd = 5'd7;
      #1 chk("iss7_ready", iss_ready, 1);
      tick();
      chk("iss7_pending", pending, 32'h80);
      rs1 = 5'd7; rs2 = 5'd7;
      #1 chk("iss7_again_ready", iss_ready, 0);
      chk("rs1_haz_pend", rs1_hazard, 1);
      chk("rs2_haz_pend", rs2_hazard, 1);
      iss_valid = 1'b0;
      tick();
      chk("rs1_haz_hold", rs1_hazard, 1);
      chk("iss7_still_blocked", iss_ready, 0);
      // writeback rd=7 while issuing a different rd=8
      r1_valid = 1'b1; r1_rd = 5'd7; r1_data = 32'h77;
      iss_valid = 1'b1; iss_rd = 5'd8;
      #1 chk("wb7_r1_ready", r1_ready, 1);
      chk("iss8_ready", iss_ready, 1);
      chk("rs1_haz_hs", rs1_hazard, 1);
      tick();
      r1_valid = 1'b0; iss_valid = 1'b0; iss_rd = 5'd7;
      #1 chk("wb7_wb_we", wb_we, 1);
      chk("wb7_wb_rd", wb_rd, 7);
      chk("set_clr_pending", pending, 32'h100);
      chk("rs1_haz_wbreg", rs1_hazard, 1);
      chk("iss7_ready_after_clr", iss_ready, 1);
      tick();
      chk("rs1_haz_cleared", rs1_hazard, 0);
      chk("rs2_haz_cleared", rs2_hazard, 0);

      // x0 handling
      iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      r0_valid = 1'b1; r0_rd = 5'd0; r0_data = 32'h1234;
      #1 chk("x0_iss_ready", iss_ready, 1);
      chk("x0_r0_ready", r0_ready, 1);
      chk("x0_rs1_haz", rs1_hazard, 0);
      tick();
      iss_valid = 1'b0; r0_valid = 1'b0;
      chk("x0_wb_we", wb_we, 0);
      chk("x0_pending", pending, 32'h100);
      chk("x0_rs1_haz_after", rs1_hazard, 0);

      // reset during in-flight write
      r0_valid = 1'b1; r0_rd = 5'd9; r0_data = 32'h99;
      iss_valid = 1'b1; iss_rd = 5'd10;
      #1 chk("rd9_r0_ready", r0_ready, 1);
      tick();
      chk("rd9_wb_we", wb_we, 1);
      chk("rd9_pending", pending, 32'h500);
      iss_valid = 1'b0; rst = 1'b1; rs1 = 5'd9;
      r0_valid = 1'b1; r1_valid = 1'b1; r1_rd = 5'd11; r1_data = 32'hBB;
      #1 chk("midrst_r0_ready", r0_ready, 0);
      chk("midrst_r1_ready", r1_ready, 0);
      tick();
      chk("midrst_wb_we", wb_we, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_rs1_haz", rs1_hazard, 0);
      rst = 1'b0;
      #1 chk("post_midrst_tie_r0", r0_ready, 1);
      chk("post_midrst_tie_r1", r1_ready, 0);
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      chk("post_midrst_wb_rd", wb_rd, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
